ipv4_tx_arb: RTL and testbench

//  Shares one IPv4 TX channel between N protocol engines (ICMP, UDP, TCP).
//  - Picks one pending requester by round-robin and offers its header metadata to IPv4 TX.
//  - On acceptance, grants the winner and forwards its payload stream.
//  - Enforces an inter-frame gap between frames.
//  - Aborts a granted frame that stalls past a timeout.

---
 rtl/ipv4_tx_arb.sv | 198 +++++++++++++++++++
 tb/tb_ipv4_tx_arb.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_tx_arb.sv
// Shares one IPv4 TX channel between N protocol engines: round-robin header offer,
// grant on accept, registered payload forwarding, inter-frame gap and stall abort.
module ipv4_tx_arb #(
    parameter int N         = 3,
    parameter int META_W    = 64,
    parameter int IFG       = 2,
    parameter int STREAM_TO = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_req_rdy,
    input  logic [N*META_W-1:0]  i_req_meta,
    input  logic [N*8-1:0]       i_req_dat,
    input  logic [N-1:0]         i_req_val,
    input  logic [N-1:0]         i_req_lst,
    output logic [N-1:0]         o_gnt,
    output logic [N-1:0]         o_abrt,
    output logic                 o_tx_rdy,
    output logic [META_W-1:0]    o_tx_meta,
    input  logic                 i_tx_acc,
    output logic [7:0]           o_tx_dat,
    output logic                 o_tx_val,
    output logic                 o_tx_lst,
    output logic                 o_tx_err,
    output logic [$clog2(N)-1:0] o_cur
);

    localparam int CUR_W  = $clog2(N);
    localparam int IDLE_W = $clog2(STREAM_TO + 1);
    localparam int GAP_W  = $clog2(IFG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_STREAM,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [CUR_W-1:0]    r_ptr;
    logic [CUR_W-1:0]    r_cur;
    logic [IDLE_W-1:0]   r_idleCnt;
    logic [GAP_W-1:0]    r_gapCnt;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        r_abrt;
    logic                r_txRdy;
    logic [META_W-1:0]   r_txMeta;
    logic [7:0]          r_txDat;
    logic                r_txVal;
    logic                r_txLst;
    logic                r_txErr;

    logic                w_found;
    logic [CUR_W-1:0]    w_pick;
    logic [CUR_W-1:0]    w_cand;
    logic [META_W-1:0]   w_pickMeta;
    logic [7:0]          w_ownDat;
    logic                w_ownVal;
    logic                w_ownLst;
    logic                w_ownRdy;

    function automatic logic [CUR_W-1:0] nextIdx(input logic [CUR_W-1:0] x);
        nextIdx = (x == CUR_W'(N - 1)) ? '0 : x + CUR_W'(1);
    endfunction

    // Round-robin search: first pending requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req_rdy[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
            w_cand = nextIdx(w_cand);
        end
    end

    always_comb begin
        w_pickMeta = '0;
        w_ownDat   = '0;
        w_ownVal   = 1'b0;
        w_ownLst   = 1'b0;
        w_ownRdy   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_pick == CUR_W'(i)) begin
                w_pickMeta = i_req_meta[i*META_W +: META_W];
            end
            if (r_cur == CUR_W'(i)) begin
                w_ownDat = i_req_dat[i*8 +: 8];
                w_ownVal = i_req_val[i];
                w_ownLst = i_req_lst[i];
                w_ownRdy = i_req_rdy[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cur     <= '0;
            r_idleCnt <= '0;
            r_gapCnt  <= '0;
            r_gnt     <= '0;
            r_abrt    <= '0;
            r_txRdy   <= 1'b0;
            r_txMeta  <= '0;
            r_txDat   <= '0;
            r_txVal   <= 1'b0;
            r_txLst   <= 1'b0;
            r_txErr   <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_abrt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cur    <= w_pick;
                        r_txMeta <= w_pickMeta;
                        r_txRdy  <= 1'b1;
                        r_state  <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (i_tx_acc) begin
                        r_txRdy   <= 1'b0;
                        r_gnt     <= N'(1) << r_cur;
                        r_idleCnt <= '0;
                        r_state   <= S_STREAM;
                    end else if (!w_ownRdy) begin
                        // Withdrawal leaves the pointer alone so this requester keeps its turn.
                        r_txRdy  <= 1'b0;
                        r_txMeta <= '0;
                        r_gapCnt <= '0;
                        r_state  <= S_GAP;
                    end
                end
                S_STREAM: begin
                    if (w_ownVal) begin
                        r_idleCnt <= '0;
                        r_txVal   <= 1'b1;
                        r_txDat   <= w_ownDat;
                        r_txLst   <= w_ownLst;
                        r_txErr   <= 1'b0;
                        if (w_ownLst) begin
                            r_ptr    <= nextIdx(r_cur);
                            r_txMeta <= '0;
                            r_gapCnt <= '0;
                            r_state  <= S_GAP;
                        end
                    end else if (r_idleCnt == IDLE_W'(STREAM_TO - 1)) begin
                        // Stalled too long: close the frame with an error-marked empty last byte.
                        r_txVal  <= 1'b1;
                        r_txLst  <= 1'b1;
                        r_txErr  <= 1'b1;
                        r_txDat  <= '0;
                        r_abrt   <= N'(1) << r_cur;
                        r_ptr    <= nextIdx(r_cur);
                        r_txMeta <= '0;
                        r_gapCnt <= '0;
                        r_state  <= S_GAP;
                    end else begin
                        r_idleCnt <= r_idleCnt + IDLE_W'(1);
                        r_txVal   <= 1'b0;
                        r_txDat   <= '0;
                        r_txLst   <= 1'b0;
                        r_txErr   <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_txVal <= 1'b0;
                    r_txDat <= '0;
                    r_txLst <= 1'b0;
                    r_txErr <= 1'b0;
                    if (r_gapCnt == GAP_W'(IFG - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_abrt    = r_abrt;
    assign o_tx_rdy  = r_txRdy;
    assign o_tx_meta = r_txMeta;
    assign o_tx_dat  = r_txDat;
    assign o_tx_val  = r_txVal;
    assign o_tx_lst  = r_txLst;
    assign o_tx_err  = r_txErr;
    assign o_cur     = r_cur;

endmodule

// File: tb/tb_ipv4_tx_arb.sv
// Bench for ipv4_tx_arb: scenario tasks plus a randomized run checked against
// a round-robin reference model of grant order and forwarded payload.
module tb_ipv4_tx_arb;

    localparam int N         = 3;
    localparam int META_W    = 64;
    localparam int IFG       = 2;
    localparam int STREAM_TO = 16;

    logic                clk = 1'b0;
    logic                rstN;
    logic [N-1:0]        reqRdy;
    logic [N*META_W-1:0] reqMeta;
    logic [N*8-1:0]      reqDat;
    logic [N-1:0]        reqVal;
    logic [N-1:0]        reqLst;
    logic                txAcc;
    logic [N-1:0]        gnt;
    logic [N-1:0]        abrt;
    logic                txRdy;
    logic [META_W-1:0]   txMeta;
    logic [7:0]          txDat;
    logic                txVal;
    logic                txLst;
    logic                txErr;
    logic [1:0]          cur;

    int total = 0;
    int bad   = 0;
    int modelPtr;
    logic [META_W-1:0] metaArr [N];

    ipv4_tx_arb #(.N(N), .META_W(META_W), .IFG(IFG), .STREAM_TO(STREAM_TO)) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_req_rdy  (reqRdy),
        .i_req_meta (reqMeta),
        .i_req_dat  (reqDat),
        .i_req_val  (reqVal),
        .i_req_lst  (reqLst),
        .o_gnt      (gnt),
        .o_abrt     (abrt),
        .o_tx_rdy   (txRdy),
        .o_tx_meta  (txMeta),
        .i_tx_acc   (txAcc),
        .o_tx_dat   (txDat),
        .o_tx_val   (txVal),
        .o_tx_lst   (txLst),
        .o_tx_err   (txErr),
        .o_cur      (cur)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference arbitration: first pending index at or after the pointer, wrapping.
    function automatic int pickOwner(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setMeta(input int i, input logic [META_W-1:0] m);
        metaArr[i] = m;
        reqMeta[i*META_W +: META_W] = m;
    endtask

    task automatic driveByte(input int i, input logic [7:0] d, input logic v, input logic l);
        reqDat[i*8 +: 8] = d;
        reqVal[i] = v;
        reqLst[i] = l;
    endtask

    task automatic waitOffer(output int n);
        n = 0;
        while (!txRdy && n < 40) begin
            tick();
            n++;
        end
        if (!txRdy) n = -1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        reqRdy = '0;
        reqVal = '0;
        reqLst = '0;
        reqDat = '0;
        reqMeta = '0;
        txAcc = 1'b0;
        repeat (2) tick();
        rstN = 1'b1;
        modelPtr = 0;
        tick();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        reqRdy = 3'b111;
        reqVal = '0;
        reqLst = '0;
        reqDat = '0;
        reqMeta = '0;
        txAcc = 1'b0;
        tick();
        total++;
        if ({gnt, abrt, txRdy, txMeta, txDat, txVal, txLst, txErr, cur} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got tx_rdy=%b gnt=%b tx_val=%b cur=%0d exp all 0", txRdy, gnt, txVal, cur);
        end
        doReset();
        tick();
        total++;
        if ({gnt, txRdy, txVal} !== '0) begin
            bad++;
            $display("[TB] FAIL idle_no_req got gnt=%b tx_rdy=%b tx_val=%b exp 0", gnt, txRdy, txVal);
        end
    endtask

    task automatic test_single();
        int n;
        logic [7:0] b [4];
        doReset();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        setMeta(0, 64'hA);
        reqRdy[0] = 1'b1;
        waitOffer(n);
        total++;
        if (n !== 1) begin bad++; $display("[TB] FAIL single_offer_latency got=%0d exp=1", n); end
        total++;
        if (txMeta !== 64'hA || cur !== 2'd0) begin
            bad++;
            $display("[TB] FAIL single_offer_meta got meta=%h cur=%0d exp meta=a cur=0", txMeta, cur);
        end
        tick();
        tick();
        total++;
        if (txRdy !== 1'b1 || txMeta !== 64'hA) begin
            bad++;
            $display("[TB] FAIL single_offer_hold got rdy=%b meta=%h exp rdy=1 meta=a", txRdy, txMeta);
        end
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        reqRdy[0] = 1'b0;
        total++;
        if (gnt !== 3'b001 || txRdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_gnt got gnt=%b rdy=%b exp gnt=001 rdy=0", gnt, txRdy);
        end
        for (int i = 0; i < 4; i++) begin
            driveByte(0, b[i], 1'b1, (i == 3));
            tick();
            total++;
            if ({txVal, txLst, txErr, txDat} !== {1'b1, (i == 3), 1'b0, b[i]}) begin
                bad++;
                $display("[TB] FAIL single_byte%0d got v=%b l=%b e=%b d=%h exp v=1 l=%b e=0 d=%h",
                         i, txVal, txLst, txErr, txDat, (i == 3), b[i]);
            end
        end
        driveByte(0, 8'h00, 1'b0, 1'b0);
        modelPtr = 1;
        setMeta(1, 64'h1111);
        reqRdy[1] = 1'b1;
        waitOffer(n);
        total++;
        if (n !== IFG + 1) begin bad++; $display("[TB] FAIL single_ifg got=%0d exp=%0d", n, IFG + 1); end
        total++;
        if (cur !== 2'(pickOwner(reqRdy, modelPtr))) begin
            bad++;
            $display("[TB] FAIL single_next_owner got=%0d exp=%0d", cur, pickOwner(reqRdy, modelPtr));
        end
    endtask

    task automatic test_round_robin();
        int n;
        int exp;
        doReset();
        for (int i = 0; i < N; i++) setMeta(i, 64'($urandom));
        reqRdy = 3'b111;
        for (int f = 0; f < 6; f++) begin
            exp = pickOwner(reqRdy, modelPtr);
            waitOffer(n);
            total++;
            if (n < 0 || cur !== 2'(exp) || txMeta !== metaArr[exp]) begin
                bad++;
                $display("[TB] FAIL rr_offer%0d got cur=%0d meta=%h wait=%0d exp cur=%0d meta=%h", f, cur, txMeta, n, exp, metaArr[exp]);
            end
            txAcc = 1'b1;
            tick();
            txAcc = 1'b0;
            reqRdy[exp] = 1'b0;
            total++;
            if (gnt !== 3'(1 << exp)) begin
                bad++;
                $display("[TB] FAIL rr_gnt%0d got=%b exp=%b", f, gnt, 3'(1 << exp));
            end
            driveByte(exp, 8'(f * 2), 1'b1, 1'b0);
            tick();
            driveByte(exp, 8'(f * 2 + 1), 1'b1, 1'b1);
            tick();
            total++;
            if ({txVal, txLst, txDat} !== {1'b1, 1'b1, 8'(f * 2 + 1)}) begin
                bad++;
                $display("[TB] FAIL rr_last%0d got v=%b l=%b d=%h exp v=1 l=1 d=%h", f, txVal, txLst, txDat, 8'(f * 2 + 1));
            end
            driveByte(exp, 8'h00, 1'b0, 1'b0);
            modelPtr = (exp + 1) % N;
            reqRdy[exp] = 1'b1;
        end
    endtask

    task automatic test_stall();
        int n;
        doReset();
        setMeta(0, 64'h10);
        setMeta(1, 64'h21);
        reqRdy = 3'b011;
        waitOffer(n);
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        reqRdy[0] = 1'b0;
        driveByte(0, 8'h55, 1'b1, 1'b0);
        tick();
        total++;
        if (txVal !== 1'b1 || txDat !== 8'h55) begin
            bad++;
            $display("[TB] FAIL stall_byte1 got v=%b d=%h exp v=1 d=55", txVal, txDat);
        end
        driveByte(0, 8'h00, 1'b0, 1'b0);
        n = 0;
        while (txErr !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== STREAM_TO) begin bad++; $display("[TB] FAIL stall_cycles got=%0d exp=%0d", n, STREAM_TO); end
        total++;
        if ({txVal, txLst, txErr, txDat} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            bad++;
            $display("[TB] FAIL abort_byte got v=%b l=%b e=%b d=%h exp v=1 l=1 e=1 d=00", txVal, txLst, txErr, txDat);
        end
        total++;
        if (abrt !== 3'b001) begin bad++; $display("[TB] FAIL abort_pulse got=%b exp=001", abrt); end
        driveByte(0, 8'h66, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (txVal !== 1'b0 || abrt !== 3'b000) begin
                bad++;
                $display("[TB] FAIL late_drop%0d got v=%b abrt=%b exp v=0 abrt=000", i, txVal, abrt);
            end
        end
        driveByte(0, 8'h00, 1'b0, 1'b0);
        waitOffer(n);
        total++;
        if (cur !== 2'd1 || txMeta !== 64'h21) begin
            bad++;
            $display("[TB] FAIL stall_next got cur=%0d meta=%h exp cur=1 meta=21", cur, txMeta);
        end
    endtask

    task automatic test_withdraw();
        int n;
        doReset();
        setMeta(0, 64'h30);
        setMeta(1, 64'h31);
        setMeta(2, 64'h32);
        reqRdy = 3'b001;
        waitOffer(n);
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        reqRdy[0] = 1'b0;
        driveByte(0, 8'h01, 1'b1, 1'b1);
        tick();
        driveByte(0, 8'h00, 1'b0, 1'b0);
        modelPtr = 1;
        reqRdy = 3'b110;
        waitOffer(n);
        total++;
        if (cur !== 2'd1) begin bad++; $display("[TB] FAIL withdraw_offer got cur=%0d exp=1", cur); end
        reqRdy[1] = 1'b0;
        tick();
        total++;
        if (txRdy !== 1'b0 || gnt !== 3'b000) begin
            bad++;
            $display("[TB] FAIL withdraw_drop got rdy=%b gnt=%b exp rdy=0 gnt=000", txRdy, gnt);
        end
        reqRdy[1] = 1'b1;
        waitOffer(n);
        total++;
        if (n < 0 || cur !== 2'(pickOwner(reqRdy, modelPtr)) || txMeta !== 64'h31) begin
            bad++;
            $display("[TB] FAIL withdraw_priority got cur=%0d meta=%h exp cur=%0d meta=31", cur, txMeta, pickOwner(reqRdy, modelPtr));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        doReset();
        setMeta(0, 64'h40);
        setMeta(2, 64'h42);
        reqRdy = 3'b100;
        waitOffer(n);
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        reqRdy[2] = 1'b0;
        driveByte(2, 8'h77, 1'b1, 1'b0);
        tick();
        total++;
        if (txVal !== 1'b1 || cur !== 2'd2) begin
            bad++;
            $display("[TB] FAIL mid_stream got v=%b cur=%0d exp v=1 cur=2", txVal, cur);
        end
        #2;
        rstN = 1'b0;
        #1;
        total++;
        if ({gnt, abrt, txRdy, txMeta, txDat, txVal, txLst, txErr, cur} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got v=%b l=%b rdy=%b cur=%0d exp all 0", txVal, txLst, txRdy, cur);
        end
        driveByte(2, 8'h00, 1'b0, 1'b0);
        reqRdy = 3'b111;
        tick();
        rstN = 1'b1;
        waitOffer(n);
        total++;
        if (cur !== 2'd0 || txMeta !== 64'h40) begin
            bad++;
            $display("[TB] FAIL reset_restart got cur=%0d meta=%h exp cur=0 meta=40", cur, txMeta);
        end
    endtask

    task automatic test_ignored();
        int n;
        doReset();
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        total++;
        if (gnt !== 3'b000 || txRdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL acc_in_idle got gnt=%b rdy=%b exp gnt=000 rdy=0", gnt, txRdy);
        end
        setMeta(0, 64'h50);
        reqRdy = 3'b001;
        waitOffer(n);
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        reqRdy[0] = 1'b0;
        driveByte(1, 8'hAA, 1'b1, 1'b0);
        driveByte(2, 8'hBB, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (txVal !== 1'b0 || txLst !== 1'b0) begin
                bad++;
                $display("[TB] FAIL nonowner_ignored%0d got v=%b l=%b exp v=0 l=0", i, txVal, txLst);
            end
        end
        driveByte(1, 8'h00, 1'b0, 1'b0);
        driveByte(2, 8'h00, 1'b0, 1'b0);
        driveByte(0, 8'hC3, 1'b1, 1'b1);
        tick();
        total++;
        if ({txVal, txLst, txDat} !== {1'b1, 1'b1, 8'hC3}) begin
            bad++;
            $display("[TB] FAIL owner_after_noise got v=%b l=%b d=%h exp v=1 l=1 d=c3", txVal, txLst, txDat);
        end
        driveByte(0, 8'h00, 1'b0, 1'b0);
        txAcc = 1'b1;
        tick();
        txAcc = 1'b0;
        tick();
        total++;
        if (gnt !== 3'b000 || txRdy !== 1'b0 || txVal !== 1'b0) begin
            bad++;
            $display("[TB] FAIL acc_in_gap got gnt=%b rdy=%b v=%b exp gnt=000 rdy=0 v=0", gnt, txRdy, txVal);
        end
    endtask

    task automatic test_random();
        int n;
        int exp;
        int len;
        logic [7:0] d;
        doReset();
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++) begin
                if (!reqRdy[i] && $urandom_range(0, 1) == 1) begin
                    setMeta(i, {32'($urandom), 32'($urandom)});
                    reqRdy[i] = 1'b1;
                end
            end
            if (reqRdy == '0) begin
                n = $urandom_range(0, N - 1);
                setMeta(n, {32'($urandom), 32'($urandom)});
                reqRdy[n] = 1'b1;
            end
            exp = pickOwner(reqRdy, modelPtr);
            waitOffer(n);
            total++;
            if (n < 0 || cur !== 2'(exp) || txMeta !== metaArr[exp]) begin
                bad++;
                $display("[TB] FAIL rand_offer%0d got cur=%0d meta=%h exp cur=%0d meta=%h", f, cur, txMeta, exp, metaArr[exp]);
            end
            repeat ($urandom_range(0, 3)) tick();
            txAcc = 1'b1;
            tick();
            txAcc = 1'b0;
            reqRdy[exp] = 1'b0;
            total++;
            if (gnt !== 3'(1 << exp)) begin
                bad++;
                $display("[TB] FAIL rand_gnt%0d got=%b exp=%b", f, gnt, 3'(1 << exp));
            end
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    driveByte(exp, 8'h00, 1'b0, 1'b0);
                    tick();
                    total++;
                    if (txVal !== 1'b0) begin bad++; $display("[TB] FAIL rand_bubble%0d got v=%b exp v=0", f, txVal); end
                end
                d = 8'($urandom);
                driveByte(exp, d, 1'b1, (b == len - 1));
                tick();
                total++;
                if ({txVal, txLst, txErr, txDat} !== {1'b1, (b == len - 1), 1'b0, d}) begin
                    bad++;
                    $display("[TB] FAIL rand_byte%0d_%0d got v=%b l=%b e=%b d=%h exp v=1 l=%b e=0 d=%h",
                             f, b, txVal, txLst, txErr, txDat, (b == len - 1), d);
                end
            end
            driveByte(exp, 8'h00, 1'b0, 1'b0);
            modelPtr = (exp + 1) % N;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_withdraw();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
